// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1rw1r_param memory model:
// the clear/run state encoding and the lane-merge used by both the
// write path and the collision write-through path.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W = 1024;

  // Bits set in bit_mask take new_word, the rest keep old_word.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0] old_word,
    input logic [MERGE_W-1:0] new_word,
    input logic [MERGE_W-1:0] bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear sequencer: sweeps every address once (one word per
// cycle) and then raises ready for the rest of operation.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  output logic                  ready,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Sweep the counter across the whole array, then park in RUN with ready set.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (cnt == {ADDR_WIDTH{1'b1}}) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign clr_en   = (state == ST_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Single-clock 1RW + 1R behavioural SRAM with byte-lane write masks,
// hardware clear after reset and same-address collision detection.
// Optional feature macro: SRAM_BYPASS_EN -- when defined, a port 1 read
// colliding with a port 0 write returns the merged write-through word;
// otherwise it returns the old stored word.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int LANE_WIDTH = 8
) (
  input  logic                             clk0,
  input  logic                             rst0_n,
  output logic                             ready,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             collision
);

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;

  if ((DATA_WIDTH % LANE_WIDTH) != 0 || DATA_WIDTH > MERGE_W) begin : g_bad_width
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of LANE_WIDTH and <= MERGE_W");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rd0, wr0, rd1, coll_now;
  logic [DATA_WIDTH-1:0] wbits0;
  logic [DATA_WIDTH-1:0] merged0;
  logic [DATA_WIDTH-1:0] rd1_data;

  sram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk0     (clk0),
    .rst0_n   (rst0_n),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Requests only count once the clear sweep has finished.
  assign rd0      = ready & ~csb0 &  web0;
  assign wr0      = ready & ~csb0 & ~web0;
  assign rd1      = ready & ~csb1;
  assign coll_now = wr0 & rd1 & (addr0 == addr1);

  // Expand the per-lane write mask into a per-bit mask.
  always_comb begin
    wbits0 = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      wbits0[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
    end
  end

  assign merged0 = DATA_WIDTH'(merge(MERGE_W'(mem[addr0]), MERGE_W'(din0), MERGE_W'(wbits0)));

  // Select the word port 1 captures; on a collision the bypass build forwards the merge.
  always_comb begin
    rd1_data = mem[addr1];
`ifdef SRAM_BYPASS_EN
    if (coll_now) begin
      rd1_data = merged0;
    end
`endif
  end

  // Storage update: the clear sweep owns the array until ready, then port 0 writes.
  always_ff @(posedge clk0) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr0) begin
      mem[addr0] <= merged0;
    end
  end

  // Registered read ports and collision flag; deselected or writing ports hold dout.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0     <= '0;
      dout1     <= '0;
      collision <= 1'b0;
    end else begin
      collision <= coll_now;
      if (rd0) begin
        dout0 <= mem[addr0];
      end
      if (rd1) begin
        dout1 <= rd1_data;
      end
    end
  end

endmodule

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised single-clock, dual-port (1 read/write + 1 read-only) behavioural SRAM with byte-lane write masks, a hardware clear sequence after reset, and same-address collision detection. It is the next-generation instruction/data memory model for the core: both ports share one clock so the pipeline fetch (port 1) and load/store unit (port 0) see deterministic, cycle-exact read-during-write behaviour.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH
- ADDR_WIDTH, 9, address bits; RAM_DEPTH = 2**ADDR_WIDTH words
- LANE_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/LANE_WIDTH

Ports:
- clk0  in  1  single clock for both ports
- rst0_n  in  1  reset, asynchronous assert, active-low
- ready  out  1  high once the clear sequence is complete; requests accepted only when high
- csb0  in  1  port 0 chip select, active-low
- web0  in  1  port 0 write enable, active-low (1 = read)
- wmask0  in  NUM_WMASKS  per-lane write enable, lane i = bits [i*LANE_WIDTH +: LANE_WIDTH]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- csb1  in  1  port 1 chip select, active-low
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- collision  out  1  one-cycle pulse: port 0 write and port 1 read to the same address in the same cycle

## Operation
- States: CLEAR, RUN.
- Reset (rst0_n low): state = CLEAR, clear counter = 0, ready = 0, dout0 = 0, dout1 = 0, collision = 0.
- CLEAR: one word per cycle, mem[counter] <= 0, counter increments; after writing RAM_DEPTH-1, go to RUN and set ready = 1. Takes exactly RAM_DEPTH cycles. csb0/csb1 ignored; douts hold 0.
- RUN, port 0 read (csb0=0, web0=1): dout0 <= mem[addr0].
- RUN, port 0 write (csb0=0, web0=0): for each lane i with wmask0[i]=1, that lane of mem[addr0] <= that lane of din0; other lanes unchanged. dout0 holds its previous value. wmask0 = 0 is a legal no-op write.
- RUN, port 1 read (csb1=0): dout1 <= mem[addr1].
- Deselected port: dout holds.
- Both ports reading the same address: both return stored data, no collision.
- Port 0 write + port 1 read, addr0 == addr1: collision = 1 for that cycle (registered, visible after the edge); dout1 per Configuration.
- Reset asserted mid-CLEAR restarts the sweep from 0. Reset asserted in RUN returns to CLEAR; memory is re-zeroed.

## Timing
- All inputs sampled on posedge clk0.
- Read latency 1: request at edge N, dout valid after edge N and stable until the next edge of an active read on that port.
- Write at edge N is visible to any read sampled at edge N+1.
- ready rises after the RAM_DEPTH-th posedge following reset release; first request is accepted at the edge where ready is already 1.
- collision is high for exactly the one cycle after the offending edge.

## Configuration
- SRAM_BYPASS_EN defined: on collision, dout1 returns write-through data: written lanes from din0, unwritten lanes from the old mem word.
- Not defined: dout1 returns the old mem word (read-before-write). collision is raised in both builds.

## Structure
- Shared package sram_pkg: state enum (CLEAR, RUN), and lane-merge function merge(old, new, mask) returning the masked word, used by both the write path and the bypass path.
- One natural sub-module: sram_clear_fsm (state register, counter, ready); storage and ports stay in the top.

## Test plan
- Reset then idle: ready low for 512 cycles (default params), high after; read port 1 at 0x000 and 0x1FF -> dout1 = 0x00000000.
- Write addr0=0x010 din0=0xDEADBEEF wmask0=4'b1111, next cycle read port 1 addr1=0x010 -> dout1 = 0xDEADBEEF one cycle later; dout0 unchanged across the write.
- Partial write wmask0=4'b0101 din0=0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44.
- Same-cycle write 0xCAFEF00D mask 4'b0011 and port 1 read at 0x010 (holding 0xDEADBEEF) -> collision = 1 for one cycle; dout1 = 0xDEADF00D with SRAM_BYPASS_EN, 0xDEADBEEF without.
- Requests with csb0=0/csb1=0 during CLEAR -> no write lands, douts remain 0; after ready, location still reads 0.
- Reset pulse in RUN after writes -> dout0/dout1/collision = 0 immediately, ready low for 512 cycles, previously written address reads 0.
